// File: rtl/burst_axi_master.sv
// AXI4 burst master: turns one host request into a single INCR burst, steering
// narrow beats onto byte lanes and folding slave responses into sticky status flags.
module burst_axi_master #(
   parameter int DATA_W  = 64,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic                i_write,
   input  logic [ADDR_W-1:0]   i_addr,
   input  logic [7:0]          i_len,
   input  logic [2:0]          i_size,
   input  logic [DATA_W-1:0]   i_wdata,
   input  logic                i_wvalid,
   output logic                o_wready,
   output logic [DATA_W-1:0]   o_rdata,
   output logic                o_rvalid,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_error,
   output logic                o_invalid,
   input  logic                i_clear,
   output logic [4:0]          o_beats,
   output logic                m_axi_awvalid,
   input  logic                m_axi_awready,
   output logic [ADDR_W-1:0]   m_axi_awaddr,
   output logic [7:0]          m_axi_awlen,
   output logic [2:0]          m_axi_awsize,
   output logic [1:0]          m_axi_awburst,
   output logic [3:0]          m_axi_awcache,
   output logic [2:0]          m_axi_awprot,
   output logic                m_axi_awlock,
   output logic [3:0]          m_axi_awqos,
   output logic                m_axi_wvalid,
   input  logic                m_axi_wready,
   output logic [DATA_W-1:0]   m_axi_wdata,
   output logic [DATA_W/8-1:0] m_axi_wstrb,
   output logic                m_axi_wlast,
   input  logic                m_axi_bvalid,
   output logic                m_axi_bready,
   input  logic [1:0]          m_axi_bresp,
   output logic                m_axi_arvalid,
   input  logic                m_axi_arready,
   output logic [ADDR_W-1:0]   m_axi_araddr,
   output logic [7:0]          m_axi_arlen,
   output logic [2:0]          m_axi_arsize,
   output logic [1:0]          m_axi_arburst,
   output logic [3:0]          m_axi_arcache,
   output logic [2:0]          m_axi_arprot,
   output logic                m_axi_arlock,
   output logic [3:0]          m_axi_arqos,
   input  logic                m_axi_rvalid,
   output logic                m_axi_rready,
   input  logic [DATA_W-1:0]   m_axi_rdata,
   input  logic [1:0]          m_axi_rresp,
   input  logic                m_axi_rlast
);

   localparam int STRB_W = DATA_W / 8;
   localparam int LANE_W = $clog2(STRB_W);
   localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_WDATA = 3'd2,
      S_WRESP = 3'd3,
      S_RDATA = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [3:0]          len_q, len_d;
   logic [2:0]          size_q, size_d;
   logic                write_q, write_d;
   logic [3:0]          idx_q, idx_d;
   logic [4:0]          beats_q, beats_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic                invalid_q, invalid_d;

   logic                start_bad_s;
   logic [ADDR_W-1:0]   align_mask_s;
   logic [19:0]         span_s;
   logic [LANE_W-1:0]   lane_s;
   logic [LANE_W+2:0]   lane_bits_s;
   logic [ADDR_W-1:0]   step_s;
   logic [4:0]          beats_sat_s;
   logic                busy_s, last_beat_s, tmo_hit_s;
   logic                aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, any_hs_s;

   function automatic logic [STRB_W-1:0] size_strb(input logic [2:0] size);
      logic [STRB_W-1:0] s;
      for (int i = 0; i < STRB_W; i++) begin
         s[i] = (i < (32'sd1 <<< size));
      end
      return s;
   endfunction

   function automatic logic [DATA_W-1:0] size_mask(input logic [2:0] size);
      logic [STRB_W-1:0] s;
      logic [DATA_W-1:0] m;
      s = size_strb(size);
      for (int i = 0; i < STRB_W; i++) begin
         m[i*8 +: 8] = {8{s[i]}};
      end
      return m;
   endfunction

   function automatic logic resp_err(input logic [1:0] resp);
      return resp[1];
   endfunction

   function automatic logic resp_dec(input logic [1:0] resp);
      return (resp == 2'b11);
   endfunction

   assign busy_s      = (state_q == S_ADDR) || (state_q == S_WDATA) ||
                        (state_q == S_WRESP) || (state_q == S_RDATA);
   assign lane_s      = addr_q[LANE_W-1:0];
   assign lane_bits_s = {lane_s, 3'b000};
   assign step_s      = ADDR_W'(1'b1) << size_q;
   assign last_beat_s = (idx_q == len_q);
   assign beats_sat_s = (beats_q == 5'd16) ? beats_q : beats_q + 5'd1;
   assign tmo_hit_s   = (TIMEOUT != 0) && ((32'(tmo_q) + 32'd1) == 32'(TIMEOUT));

   assign m_axi_awvalid = (state_q == S_ADDR) && write_q;
   assign m_axi_arvalid = (state_q == S_ADDR) && !write_q;
   assign m_axi_wvalid  = (state_q == S_WDATA) && i_wvalid;
   assign o_wready      = (state_q == S_WDATA) && m_axi_wready;
   assign m_axi_bready  = (state_q == S_WRESP);
   assign m_axi_rready  = (state_q == S_RDATA);

   assign aw_hs_s  = m_axi_awvalid && m_axi_awready;
   assign ar_hs_s  = m_axi_arvalid && m_axi_arready;
   assign w_hs_s   = m_axi_wvalid && m_axi_wready;
   assign b_hs_s   = m_axi_bvalid && m_axi_bready;
   assign r_hs_s   = m_axi_rvalid && m_axi_rready;
   assign any_hs_s = aw_hs_s || ar_hs_s || w_hs_s || b_hs_s || r_hs_s;

   assign m_axi_awaddr  = addr_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_awlen   = {4'b0000, len_q};
   assign m_axi_arlen   = {4'b0000, len_q};
   assign m_axi_awsize  = size_q;
   assign m_axi_arsize  = size_q;
   assign m_axi_awburst = 2'b01;
   assign m_axi_arburst = 2'b01;
   assign m_axi_awcache = 4'b0011;
   assign m_axi_arcache = 4'b0011;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_awqos   = 4'b0000;
   assign m_axi_arqos   = 4'b0000;

   // Host data lands on the byte lane of the current beat address; reads come back down.
   assign m_axi_wdata = (state_q == S_WDATA) ? (i_wdata << lane_bits_s) : {DATA_W{1'b0}};
   assign m_axi_wstrb = (state_q == S_WDATA) ? (size_strb(size_q) << lane_s) : {STRB_W{1'b0}};
   assign m_axi_wlast = (state_q == S_WDATA) && last_beat_s;
   assign o_rvalid    = r_hs_s;
   assign o_rdata     = r_hs_s ? ((m_axi_rdata >> lane_bits_s) & size_mask(size_q))
                               : {DATA_W{1'b0}};

   assign o_busy    = busy_s;
   assign o_done    = done_q;
   assign o_error   = error_q;
   assign o_invalid = invalid_q;
   assign o_beats   = beats_q;

   // Screen a start request: length, size, alignment and 4KB boundary.
   always_comb begin
      align_mask_s = (ADDR_W'(1'b1) << i_size) - ADDR_W'(1'b1);
      span_s       = {8'h00, i_addr[11:0]} + (({12'h000, i_len} + 20'd1) << i_size);
      if ((i_len > 8'd15) || (i_size > 3'(LANE_W)) ||
          ((i_addr & align_mask_s) != {ADDR_W{1'b0}}) || (span_s > 20'd4096)) begin
         start_bad_s = 1'b1;
      end else begin
         start_bad_s = 1'b0;
      end
   end

   // Next-state, beat tracking, response accumulation and timeout abort.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      size_d    = size_q;
      write_d   = write_q;
      idx_d     = idx_q;
      beats_d   = beats_q;
      tmo_d     = tmo_q;
      done_d    = done_q;
      error_d   = error_q;
      invalid_d = invalid_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               idx_d     = 4'd0;
               beats_d   = 5'd0;
               done_d    = start_bad_s;
               error_d   = start_bad_s;
               invalid_d = start_bad_s;
               if (start_bad_s) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ADDR;
                  addr_d  = i_addr;
                  len_d   = i_len[3:0];
                  size_d  = i_size;
                  write_d = i_write;
               end
            end else if (i_clear) begin
               state_d   = S_IDLE;
               done_d    = 1'b0;
               error_d   = 1'b0;
               invalid_d = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         S_ADDR: begin
            if (aw_hs_s) begin
               state_d = S_WDATA;
            end else if (ar_hs_s) begin
               state_d = S_RDATA;
            end else begin
               state_d = S_ADDR;
            end
         end
         S_WDATA: begin
            if (w_hs_s) begin
               addr_d  = addr_q + step_s;
               beats_d = beats_sat_s;
               if (last_beat_s) begin
                  state_d = S_WRESP;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end else begin
               state_d = S_WDATA;
            end
         end
         S_WRESP: begin
            if (b_hs_s) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               error_d   = error_q | resp_err(m_axi_bresp);
               invalid_d = invalid_q | resp_dec(m_axi_bresp);
            end else begin
               state_d = S_WRESP;
            end
         end
         S_RDATA: begin
            if (r_hs_s) begin
               addr_d    = addr_q + step_s;
               beats_d   = beats_sat_s;
               // rlast disagreeing with the requested length is itself an error
               error_d   = error_q | resp_err(m_axi_rresp) | (m_axi_rlast ^ last_beat_s);
               invalid_d = invalid_q | resp_dec(m_axi_rresp);
               if (m_axi_rlast || last_beat_s) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end else begin
               state_d = S_RDATA;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (busy_s) begin
         if (any_hs_s) begin
            tmo_d = {TMO_W{1'b0}};
         end else if (tmo_hit_s) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            error_d   = 1'b1;
            invalid_d = 1'b0;
            tmo_d     = {TMO_W{1'b0}};
         end else begin
            tmo_d = tmo_q + TMO_W'(1'b1);
         end
      end else begin
         tmo_d = {TMO_W{1'b0}};
      end
   end

   // State and status registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         addr_q    <= {ADDR_W{1'b0}};
         len_q     <= 4'd0;
         size_q    <= 3'd0;
         write_q   <= 1'b0;
         idx_q     <= 4'd0;
         beats_q   <= 5'd0;
         tmo_q     <= {TMO_W{1'b0}};
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         invalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         size_q    <= size_d;
         write_q   <= write_d;
         idx_q     <= idx_d;
         beats_q   <= beats_d;
         tmo_q     <= tmo_d;
         done_q    <= done_d;
         error_q   <= error_d;
         invalid_q <= invalid_d;
      end
   end

endmodule

// File: tb/tb_burst_axi_master.sv
// Scoreboard bench for burst_axi_master: expected W beats and host read data are
// queued when stimulus is driven and compared when the DUT produces them.
module tb_burst_axi_master;

   logic        clk = 1'b0;
   logic        i_rst, i_start, i_write, i_wvalid, i_clear;
   logic [31:0] i_addr;
   logic [7:0]  i_len;
   logic [2:0]  i_size;
   logic [63:0] i_wdata;
   logic        o_wready, o_rvalid, o_busy, o_done, o_error, o_invalid;
   logic [63:0] o_rdata;
   logic [4:0]  o_beats;
   logic        m_axi_awvalid, m_axi_awready, m_axi_awlock;
   logic [31:0] m_axi_awaddr, m_axi_araddr;
   logic [7:0]  m_axi_awlen, m_axi_arlen;
   logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
   logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
   logic [3:0]  m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
   logic        m_axi_wvalid, m_axi_wready, m_axi_wlast;
   logic [63:0] m_axi_wdata, m_axi_rdata;
   logic [7:0]  m_axi_wstrb;
   logic        m_axi_bvalid, m_axi_bready;
   logic        m_axi_arvalid, m_axi_arready, m_axi_arlock;
   logic        m_axi_rvalid, m_axi_rready, m_axi_rlast;

   int n_checks = 0;
   int n_fail   = 0;
   int rv_cnt   = 0;
   logic [72:0] exp_w_q[$];
   logic [63:0] exp_r_q[$];
   logic [72:0] mon_w_e;
   logic [63:0] mon_r_e;

   always #5 clk = ~clk;

   burst_axi_master #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(8)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_write(i_write),
      .i_addr(i_addr), .i_len(i_len), .i_size(i_size),
      .i_wdata(i_wdata), .i_wvalid(i_wvalid), .o_wready(o_wready),
      .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_busy(o_busy), .o_done(o_done),
      .o_error(o_error), .o_invalid(o_invalid), .i_clear(i_clear), .o_beats(o_beats),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
      .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache),
      .m_axi_awprot(m_axi_awprot), .m_axi_awlock(m_axi_awlock), .m_axi_awqos(m_axi_awqos),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
      .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
      .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache),
      .m_axi_arprot(m_axi_arprot), .m_axi_arlock(m_axi_arlock), .m_axi_arqos(m_axi_arqos),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
      .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumers: W beats on the AXI side, read beats on the host side.
   always @(negedge clk) begin
      if (!i_rst) begin
         if (m_axi_wvalid && m_axi_wready) begin
            if (exp_w_q.size() == 0) begin
               check_eq("w_unexpected", 64'd1, 64'd0);
            end else begin
               mon_w_e = exp_w_q.pop_front();
               check_eq("wdata", m_axi_wdata, mon_w_e[63:0]);
               check_eq("wstrb", 64'(m_axi_wstrb), 64'(mon_w_e[71:64]));
               check_eq("wlast", 64'(m_axi_wlast), 64'(mon_w_e[72]));
            end
         end
         if (o_rvalid) begin
            rv_cnt++;
            if (exp_r_q.size() == 0) begin
               check_eq("r_unexpected", 64'd1, 64'd0);
            end else begin
               mon_r_e = exp_r_q.pop_front();
               check_eq("rdata", o_rdata, mon_r_e);
            end
         end
      end
   end

   task automatic do_start(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size);
      i_start = 1'b1; i_write = wr; i_addr = addr; i_len = len; i_size = size;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   // Host supplies nbeats LSB-aligned beats; the expected AXI beat is queued first.
   task automatic host_wbeats(input logic [31:0] addr, input logic [2:0] size, input int nbeats,
                              input int len, input logic [63:0] seed);
      logic [31:0] a;
      logic [63:0] d, bmask, edata;
      logic [7:0]  estrb;
      int guard;
      a = addr;
      bmask = (size == 3'd3) ? {64{1'b1}} : ((64'd1 << (32'd8 << size)) - 64'd1);
      for (int k = 0; k < nbeats; k++) begin
         d     = (seed + 64'(k)) & bmask;
         edata = d << {a[2:0], 3'b000};
         estrb = 8'(((16'd1 << (16'd1 << size)) - 16'd1) << a[2:0]);
         exp_w_q.push_back({(k == len), estrb, edata});
         i_wvalid = 1'b1; i_wdata = d;
         guard = 0;
         @(negedge clk);
         while (!o_wready && guard < 40) begin @(negedge clk); guard++; end
         if (guard >= 40) check_eq("w_handshake_timeout", 64'd0, 64'd1);
         @(posedge clk); #1;
         a = a + (32'd1 << size);
      end
      i_wvalid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int guard;
      guard = 0;
      while (!o_done && guard < 40) begin @(negedge clk); guard++; end
      check_eq(tag, 64'(o_done), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic finish_write(input logic [1:0] resp, input string tag);
      m_axi_bvalid = 1'b1; m_axi_bresp = resp;
      wait_done(tag);
      m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
   endtask

   task automatic slave_rbeat(input logic [63:0] data, input logic last, input logic [1:0] resp,
                              input logic [63:0] exp);
      m_axi_rvalid = 1'b1; m_axi_rdata = data; m_axi_rlast = last; m_axi_rresp = resp;
      exp_r_q.push_back(exp);
      @(posedge clk); #1;
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] bad_addr[4] = '{32'h0000_0FF8, 32'h0000_1002, 32'h0000_1000, 32'h0000_1000};
      logic [7:0]  bad_len[4]  = '{8'd1, 8'd0, 8'd0, 8'd16};
      logic [2:0]  bad_size[4] = '{3'd3, 3'd2, 3'd4, 3'd0};
      int cnt, guard;

      i_rst = 1'b1; i_start = 1'b0; i_write = 1'b0; i_addr = 32'd0; i_len = 8'd0;
      i_size = 3'd0; i_wdata = 64'd0; i_wvalid = 1'b0; i_clear = 1'b0;
      m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
      m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; m_axi_rvalid = 1'b0;
      m_axi_rdata = 64'd0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_status", 64'({o_busy, o_done, o_error, o_invalid, o_rvalid, o_wready}), 64'd0);
      check_eq("reset_valids", 64'({m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_bready, m_axi_rready}), 64'd0);
      check_eq("reset_beats", 64'(o_beats), 64'd0);
      i_rst = 1'b0;
      @(posedge clk); #1;

      // 4-beat full-width write
      do_start(1'b1, 32'h0000_1000, 8'd3, 3'd3);
      check_eq("w1_awvalid", 64'(m_axi_awvalid), 64'd1);
      check_eq("w1_busy", 64'(o_busy), 64'd1);
      check_eq("w1_awaddr", 64'(m_axi_awaddr), 64'h1000);
      check_eq("w1_awlen", 64'(m_axi_awlen), 64'd3);
      check_eq("w1_awsize", 64'(m_axi_awsize), 64'd3);
      check_eq("aw_const", 64'({m_axi_awburst, m_axi_awcache, m_axi_awprot, m_axi_awlock, m_axi_awqos}),
               64'({2'b01, 4'b0011, 3'b000, 1'b0, 4'b0000}));
      check_eq("ar_const", 64'({m_axi_arburst, m_axi_arcache, m_axi_arprot, m_axi_arlock, m_axi_arqos}),
               64'({2'b01, 4'b0011, 3'b000, 1'b0, 4'b0000}));
      host_wbeats(32'h0000_1000, 3'd3, 4, 3, 64'h1122_3344_5566_7700);
      finish_write(2'b00, "w1_done");
      check_eq("w1_error", 64'({o_error, o_invalid}), 64'd0);
      check_eq("w1_beats", 64'(o_beats), 64'd4);

      // narrow read starting on the upper lane
      do_start(1'b0, 32'h0000_2004, 8'd1, 3'd2);
      check_eq("r1_arvalid", 64'(m_axi_arvalid), 64'd1);
      check_eq("r1_arsize", 64'(m_axi_arsize), 64'd2);
      check_eq("r1_arlen", 64'(m_axi_arlen), 64'd1);
      @(posedge clk); #1;
      slave_rbeat(64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 2'b00, 64'h0000_0000_AAAA_BBBB);
      slave_rbeat(64'h1111_2222_3333_4444, 1'b1, 2'b00, 64'h0000_0000_3333_4444);
      wait_done("r1_done");
      check_eq("r1_error", 64'(o_error), 64'd0);
      check_eq("r1_beats", 64'(o_beats), 64'd2);

      // rejected starts: 4KB crossing, misalignment, oversize, overlong
      for (int i = 0; i < 4; i++) begin
         i_start = 1'b1; i_write = (i == 0) || (i == 3); i_addr = bad_addr[i];
         i_len = bad_len[i]; i_size = bad_size[i];
         @(negedge clk);
         check_eq($sformatf("bad%0d_no_addr", i), 64'({m_axi_awvalid, m_axi_arvalid}), 64'd0);
         @(posedge clk); #1;
         i_start = 1'b0;
         check_eq($sformatf("bad%0d_flags", i), 64'({o_done, o_error, o_invalid}), 64'b111);
         check_eq($sformatf("bad%0d_beats", i), 64'(o_beats), 64'd0);
         check_eq($sformatf("bad%0d_quiet", i), 64'({o_busy, m_axi_awvalid, m_axi_arvalid}), 64'd0);
      end
      i_clear = 1'b1;
      @(posedge clk); #1;
      i_clear = 1'b0;
      check_eq("clear_flags", 64'({o_done, o_error, o_invalid}), 64'd0);

      // read ending exactly on the 4KB boundary is legal
      do_start(1'b0, 32'h0000_0FF8, 8'd0, 3'd3);
      check_eq("edge_arvalid", 64'(m_axi_arvalid), 64'd1);
      @(posedge clk); #1;
      slave_rbeat(64'h0123_4567_89AB_CDEF, 1'b1, 2'b00, 64'h0123_4567_89AB_CDEF);
      wait_done("edge_done");
      check_eq("edge_flags", 64'({o_error, o_invalid}), 64'd0);

      // narrow write steered across lanes
      do_start(1'b1, 32'h0000_6004, 8'd1, 3'd2);
      check_eq("w2_awsize", 64'(m_axi_awsize), 64'd2);
      host_wbeats(32'h0000_6004, 3'd2, 2, 1, 64'hDEAD_BEEF_0000_0010);
      finish_write(2'b00, "w2_done");
      check_eq("w2_beats", 64'(o_beats), 64'd2);

      // 4-beat read with SLVERR on beat 1 and a start pulse that must be ignored
      rv_cnt = 0;
      do_start(1'b0, 32'h0000_3000, 8'd3, 3'd3);
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         i_start = (k == 2); i_write = 1'b1;
         slave_rbeat(64'hF000_0000_0000_0000 + 64'(k), (k == 3), (k == 1) ? 2'b10 : 2'b00,
                     64'hF000_0000_0000_0000 + 64'(k));
      end
      i_start = 1'b0;
      wait_done("slv_done");
      check_eq("slv_pulses", 64'(rv_cnt), 64'd4);
      check_eq("slv_flags", 64'({o_error, o_invalid}), 64'b10);
      check_eq("slv_beats", 64'(o_beats), 64'd4);

      // early rlast on a 4-beat read; start from DONE clears old flags
      rv_cnt = 0;
      do_start(1'b0, 32'h0000_3100, 8'd3, 3'd3);
      check_eq("early_flags_cleared", 64'({o_done, o_error, o_busy}), 64'b001);
      @(posedge clk); #1;
      slave_rbeat(64'h0000_0000_0000_00A0, 1'b0, 2'b00, 64'h0000_0000_0000_00A0);
      slave_rbeat(64'h0000_0000_0000_00A1, 1'b1, 2'b00, 64'h0000_0000_0000_00A1);
      wait_done("early_done");
      check_eq("early_pulses", 64'(rv_cnt), 64'd2);
      check_eq("early_flags", 64'({o_error, o_invalid}), 64'b10);
      check_eq("early_beats", 64'(o_beats), 64'd2);

      // DECERR write response
      do_start(1'b1, 32'h0000_7000, 8'd0, 3'd3);
      host_wbeats(32'h0000_7000, 3'd3, 1, 0, 64'h0000_0000_0000_7777);
      finish_write(2'b11, "dec_done");
      check_eq("dec_flags", 64'({o_error, o_invalid}), 64'b11);
      check_eq("dec_beats", 64'(o_beats), 64'd1);

      // awready stuck low: abort after TIMEOUT idle cycles
      m_axi_awready = 1'b0;
      do_start(1'b1, 32'h0000_8000, 8'd0, 3'd3);
      cnt = 0; guard = 0;
      @(negedge clk);
      while (m_axi_awvalid && guard < 40) begin cnt++; @(negedge clk); guard++; end
      check_eq("tmo_awvalid_cycles", 64'(cnt), 64'd8);
      check_eq("tmo_flags", 64'({o_done, o_error, o_invalid, o_busy}), 64'b1100);
      @(posedge clk); #1;
      m_axi_awready = 1'b1;

      // reset mid-burst, then a fresh start
      do_start(1'b1, 32'h0000_4000, 8'd3, 3'd3);
      host_wbeats(32'h0000_4000, 3'd3, 2, 3, 64'h0000_0000_4444_0000);
      i_rst = 1'b1;
      @(posedge clk); #1;
      check_eq("rst_valids", 64'({m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_bready, m_axi_rready}), 64'd0);
      check_eq("rst_status", 64'({o_busy, o_done, o_error, o_invalid, o_wready}), 64'd0);
      check_eq("rst_beats", 64'(o_beats), 64'd0);
      i_rst = 1'b0;
      @(posedge clk); #1;
      do_start(1'b1, 32'h0000_5000, 8'd0, 3'd3);
      check_eq("post_rst_awvalid", 64'(m_axi_awvalid), 64'd1);
      host_wbeats(32'h0000_5000, 3'd3, 1, 0, 64'h5555_0000_0000_0001);
      finish_write(2'b00, "post_rst_done");
      check_eq("post_rst_flags", 64'({o_error, o_invalid}), 64'd0);
      check_eq("post_rst_beats", 64'(o_beats), 64'd1);

      check_eq("w_queue_empty", 64'(exp_w_q.size()), 64'd0);
      check_eq("r_queue_empty", 64'(exp_r_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/burst_axi_master.md
BURST_AXI_MASTER -- requirements
Module: burst_axi_master

Interface
REQ-001 DATA_W, 64, AXI and host data width in bits; legal values 32 and 64.
REQ-002 ADDR_W, 32, address width.
REQ-003 TIMEOUT, 1023, idle-handshake cycles before abort; 0 disables the timeout.
REQ-004 i_clk  in  1  single clock; all logic on the rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_start  in  1  request; sampled only in IDLE or DONE.
REQ-007 i_write  in  1  1 = write burst, 0 = read burst.
REQ-008 i_addr  in  ADDR_W  start address.
REQ-009 i_len  in  8  beats minus one; legal range 0..15.
REQ-010 i_size  in  3  beat size, log2 bytes.
REQ-011 i_wdata / i_wvalid / o_wready  in/in/out  DATA_W/1/1  host write-beat stream, LSB-aligned.
REQ-012 o_rdata / o_rvalid  out  DATA_W/1  host read-beat stream, LSB-aligned, no backpressure.
REQ-013 o_busy, o_done, o_error, o_invalid  out  1 each  status; i_clear  in  1  clears done/error/invalid.
REQ-014 o_beats  out  5  beats completed in the last transaction.
REQ-015 AXI4 master ports: aw{valid,ready,addr,len,size,burst}, w{valid,ready,data,strb,last}, b{valid,ready,resp}, ar{valid,ready,addr,len,size,burst}, r{valid,ready,data,resp,last}.
REQ-016 Constant outputs: burst=INCR, cache=4'b0011, prot=0, lock=0, qos=0.

Function
REQ-017 States: IDLE, ADDR, WDATA, WRESP, RDATA, DONE.
REQ-018 An i_start is invalid if any of these holds: i_len>15; i_size>log2(DATA_W/8); i_addr not aligned to i_size; or addr[11:0]+((i_len+1)<<i_size) > 4096 (4KB crossing).
REQ-019 Invalid start: no AXI traffic; DONE entered next cycle with o_done=o_error=o_invalid=1 and o_beats=0.
REQ-020 Valid start: address, length, size and direction are registered; ADDR is entered; aw/arvalid is asserted the next cycle; o_busy=1 from that cycle until DONE.
REQ-021 a*valid is held with stable fields until a*ready; after the handshake the state is WDATA (write) or RDATA (read).
REQ-022 WDATA: m_axi_wvalid=i_wvalid, o_wready=m_axi_wready, wdata=i_wdata shifted to the lane given by beat address mod DATA_W/8.
REQ-023 wstrb = ((1<<(1<<size))-1) shifted by the same lane offset.
REQ-024 Beat address advances by 1<<size on each handshake; the lane offset wraps modulo DATA_W/8.
REQ-025 wlast=1 exactly on beat index == len; the handshake on that beat leads to WRESP.
REQ-026 WRESP: bready=1; on bvalid, DONE is entered.
REQ-027 RDATA: rready=1; o_rvalid = rvalid&&rready; o_rdata = rdata shifted down by the lane and masked to the size.
REQ-028 RDATA ends on rlast or beat index == len, whichever comes first; any mismatch between rlast and len sets o_error.
REQ-029 Response accumulation is sticky across the burst: SLVERR gives error; DECERR gives error+invalid; all beats are still accepted.
REQ-030 Timeout counter: reset by any AXI handshake and while in IDLE/DONE. When it reaches TIMEOUT, all valids/readies deassert and DONE is entered with error=1, invalid=0. This is fatal; the slave needs a reset.
REQ-031 DONE: flags hold until i_clear or i_start. i_start in DONE clears the flags and is processed as in IDLE. i_start and i_clear in the same cycle: start wins.
REQ-032 i_start while o_busy=1 is ignored.
REQ-033 o_beats counts completed data handshakes and saturates at 16.

Reset
REQ-034 Synchronous reset in any state gives state IDLE, all counters 0, and every output 0 (including valids/readies, o_rdata, o_beats) by the next edge. A reset mid-burst abandons the transfer with no completion flags.

Verification
REQ-035 DATA_W=64, write 0x1000, len=3, size=3, 4 host beats, ready always high, bresp OKAY -> awlen=3; 4 W beats with wstrb 0xFF; wlast on beat 4; o_done=1, o_error=0, o_beats=4.
REQ-036 Read 0x2004, size=2, len=1 -> arsize=2; beat0 rdata[63:32] appears on o_rdata[31:0]; beat1 rdata[31:0] appears on o_rdata[31:0]; upper bits 0.
REQ-037 Write 0x0FF8, size=3, len=1 -> no awvalid; next cycle o_done=o_error=o_invalid=1.
REQ-038 Read of 4 beats with SLVERR on beat 1 -> 4 o_rvalid pulses, o_error=1, o_invalid=0, o_beats=4.
REQ-039 TIMEOUT=8, awready held 0 -> awvalid drops after 8 cycles; o_done=1, o_error=1.
REQ-040 i_rst after 2 W beats of a 4-beat write -> next cycle all valids 0, o_busy=0, o_done=0; a new start then succeeds.
